lookahead_route_unit: RTL and testbench

- Parametrised, pipelined lookahead route computation for the mesh router.
- For every input port it computes the output cardinal the packet will take at the neighbouring tile in direction NEXT_TILE_CARDINAL.
- Supports row-first (XY-row) or column-first ordering, arbitrary port count and coordinate widths.
- Adds a registered valid/ready stage plus per-port backtrack/off-mesh error detection with saturating counters.

---
 rtl/router_pkg.sv | 32 +++
 rtl/lookahead_route_calc.sv | 64 ++++++
 rtl/lookahead_route_unit.sv | 96 +++++++++
 tb/tb_lookahead_route_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared mesh-router types: cardinal directions, port-to-direction map and
// route ordering modes used by the lookahead route logic.
package router_pkg;

    typedef enum logic [2:0] {
        NORTH         = 3'd0,
        EAST          = 3'd1,
        SOUTH         = 3'd2,
        WEST          = 3'd3,
        LOCAL         = 3'd4,
        NULL_CARDINAL = 3'd7
    } t_cardinal;

    typedef enum logic {
        ROW_FIRST = 1'b0,
        COL_FIRST = 1'b1
    } t_route_mode;

    localparam t_cardinal PORT_CARD [5] = '{NORTH, EAST, SOUTH, WEST, LOCAL};

    // Non-neighbour directions have no opposite and map to NULL_CARDINAL.
    function automatic t_cardinal opposite_card(input t_cardinal c);
        case (c)
            NORTH:   return SOUTH;
            SOUTH:   return NORTH;
            EAST:    return WEST;
            WEST:    return EAST;
            default: return NULL_CARDINAL;
        endcase
    endfunction

endpackage

// File: rtl/lookahead_route_calc.sv
// Combinational single-port lookahead route: next tile id, route decision
// at that tile, and backtrack / off-mesh detection.
module lookahead_route_calc
    import router_pkg::*;
#(
    parameter int          COL_W              = 4,
    parameter int          ROW_W              = 4,
    parameter t_route_mode ROUTE_MODE         = ROW_FIRST,
    parameter t_cardinal   NEXT_TILE_CARDINAL = NULL_CARDINAL
) (
    input  logic [COL_W+ROW_W-1:0] i_local_id,
    input  logic [COL_W+ROW_W-1:0] i_addr,
    input  logic                   i_valid,
    output logic [2:0]             o_card,
    output logic                   o_backtrack,
    output logic                   o_off_mesh
);
    logic [ROW_W:0]   w_row_ext;
    logic [COL_W:0]   w_col_ext;
    logic [ROW_W-1:0] w_tgt_row;
    logic [COL_W-1:0] w_tgt_col;
    logic             w_wrap;
    t_cardinal        w_row_card;
    t_cardinal        w_col_card;
    t_cardinal        w_card;

    assign w_tgt_row = i_addr[ROW_W-1:0];
    assign w_tgt_col = i_addr[COL_W+ROW_W-1:ROW_W];

    // The extra top bit catches carry/borrow out of the field.
    always_comb begin
        w_row_ext = {1'b0, i_local_id[ROW_W-1:0]};
        w_col_ext = {1'b0, i_local_id[COL_W+ROW_W-1:ROW_W]};
        case (NEXT_TILE_CARDINAL)
            NORTH:   w_row_ext = {1'b0, i_local_id[ROW_W-1:0]} - (ROW_W+1)'(1);
            SOUTH:   w_row_ext = {1'b0, i_local_id[ROW_W-1:0]} + (ROW_W+1)'(1);
            EAST:    w_col_ext = {1'b0, i_local_id[COL_W+ROW_W-1:ROW_W]} + (COL_W+1)'(1);
            WEST:    w_col_ext = {1'b0, i_local_id[COL_W+ROW_W-1:ROW_W]} - (COL_W+1)'(1);
            default: ;
        endcase
    end

    assign w_wrap = w_row_ext[ROW_W] | w_col_ext[COL_W];

    always_comb begin
        w_row_card = LOCAL;
        w_col_card = LOCAL;
        if (w_tgt_row < w_row_ext[ROW_W-1:0])      w_row_card = NORTH;
        else if (w_tgt_row > w_row_ext[ROW_W-1:0]) w_row_card = SOUTH;
        if (w_tgt_col < w_col_ext[COL_W-1:0])      w_col_card = WEST;
        else if (w_tgt_col > w_col_ext[COL_W-1:0]) w_col_card = EAST;

        if (ROUTE_MODE == ROW_FIRST) w_card = (w_row_card != LOCAL) ? w_row_card : w_col_card;
        else                         w_card = (w_col_card != LOCAL) ? w_col_card : w_row_card;
        if (!i_valid || w_wrap) w_card = NULL_CARDINAL;
    end

    assign o_card      = w_card;
    assign o_off_mesh  = i_valid && w_wrap;
    assign o_backtrack = i_valid && !w_wrap &&
                         (opposite_card(NEXT_TILE_CARDINAL) != NULL_CARDINAL) &&
                         (w_card == opposite_card(NEXT_TILE_CARDINAL));

endmodule

// File: rtl/lookahead_route_unit.sv
// Per-port registered lookahead route stage with valid/ready handshake and
// sticky error flags plus saturating error counters.
module lookahead_route_unit
    import router_pkg::*;
#(
    parameter int          NUM_PORTS          = 5,
    parameter int          COL_W              = 4,
    parameter int          ROW_W              = 4,
    parameter t_route_mode ROUTE_MODE         = ROW_FIRST,
    parameter t_cardinal   NEXT_TILE_CARDINAL = NULL_CARDINAL,
    parameter int          ERR_CNT_W          = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [COL_W+ROW_W-1:0]                     local_tile_id,
    input  logic [NUM_PORTS-1:0]                       in_req_valid,
    input  logic [NUM_PORTS-1:0][COL_W+ROW_W-1:0]      in_req_addr,
    output logic [NUM_PORTS-1:0]                       in_req_ready,
    output logic [NUM_PORTS-1:0]                       out_req_valid,
    input  logic [NUM_PORTS-1:0]                       out_req_ready,
    output logic [NUM_PORTS-1:0][2:0]                  out_next_card,
    output logic [NUM_PORTS-1:0][COL_W+ROW_W-1:0]      out_req_addr,
    output logic [NUM_PORTS-1:0]                       err_backtrack,
    output logic [NUM_PORTS-1:0]                       err_off_mesh,
    output logic [NUM_PORTS-1:0][ERR_CNT_W-1:0]        err_cnt,
    input  logic                                       err_clr
);
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [2:0]             w_card;
        logic                   w_bt;
        logic                   w_om;
        logic                   w_xfer;
        logic                   r_valid;
        logic [2:0]             r_card;
        logic [COL_W+ROW_W-1:0] r_addr;
        logic                   r_bt;
        logic                   r_om;
        logic [ERR_CNT_W-1:0]   r_cnt;

        lookahead_route_calc #(
            .COL_W              (COL_W),
            .ROW_W              (ROW_W),
            .ROUTE_MODE         (ROUTE_MODE),
            .NEXT_TILE_CARDINAL (NEXT_TILE_CARDINAL)
        ) u_calc (
            .i_local_id  (local_tile_id),
            .i_addr      (in_req_addr[p]),
            .i_valid     (in_req_valid[p]),
            .o_card      (w_card),
            .o_backtrack (w_bt),
            .o_off_mesh  (w_om)
        );

        assign in_req_ready[p] = !r_valid || out_req_ready[p];
        assign w_xfer          = in_req_valid[p] && in_req_ready[p];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_card  <= NULL_CARDINAL;
                r_addr  <= '0;
            end else if (w_xfer) begin
                r_valid <= 1'b1;
                r_card  <= w_card;
                r_addr  <= in_req_addr[p];
            end else if (out_req_ready[p]) begin
                r_valid <= 1'b0;
            end
        end

        // Clear has priority over an error arriving in the same cycle.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_bt  <= 1'b0;
                r_om  <= 1'b0;
                r_cnt <= '0;
            end else if (err_clr) begin
                r_bt  <= 1'b0;
                r_om  <= 1'b0;
                r_cnt <= '0;
            end else if (w_xfer && (w_bt || w_om)) begin
                r_bt <= r_bt | w_bt;
                r_om <= r_om | w_om;
                if (r_cnt != {ERR_CNT_W{1'b1}}) r_cnt <= r_cnt + ERR_CNT_W'(1);
            end
        end

        assign out_req_valid[p] = r_valid;
        assign out_next_card[p] = r_card;
        assign out_req_addr[p]  = r_addr;
        assign err_backtrack[p] = r_bt;
        assign err_off_mesh[p]  = r_om;
        assign err_cnt[p]       = r_cnt;
    end

endmodule

// File: tb/tb_lookahead_route_unit.sv
// Drives four differently parameterised route units from shared inputs and
// compares each against an integer-arithmetic reference model every cycle.
module tb_lookahead_route_unit;
    import router_pkg::*;

    localparam int NP = 5;
    localparam int TW = 8;
    localparam int NI = 4;
    localparam t_cardinal   NTC [NI] = '{EAST, EAST, WEST, NULL_CARDINAL};
    localparam t_route_mode RM  [NI] = '{ROW_FIRST, COL_FIRST, ROW_FIRST, ROW_FIRST};
    localparam int          EW  [NI] = '{2, 8, 8, 8};

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      err_clr;
    logic [TW-1:0]             local_id;
    logic [NP-1:0]             ivld;
    logic [NP-1:0][TW-1:0]     iaddr;
    logic [NP-1:0]             ordy;

    logic [NP-1:0]             irdy [NI];
    logic [NP-1:0]             ovld [NI];
    logic [NP-1:0][2:0]        card [NI];
    logic [NP-1:0][TW-1:0]     oaddr[NI];
    logic [NP-1:0]             bt   [NI];
    logic [NP-1:0]             om   [NI];
    logic [7:0]                cnt  [NI][NP];

    bit m_vld [NI][NP];
    int m_card[NI][NP];
    int m_addr[NI][NP];
    bit m_bt  [NI][NP];
    bit m_om  [NI][NP];
    int m_cnt [NI][NP];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [NP-1:0][EW[g]-1:0] w_cnt;
        lookahead_route_unit #(
            .NUM_PORTS(NP), .COL_W(4), .ROW_W(4), .ROUTE_MODE(RM[g]),
            .NEXT_TILE_CARDINAL(NTC[g]), .ERR_CNT_W(EW[g])
        ) u_dut (
            .clk(clk), .rst(rst), .local_tile_id(local_id),
            .in_req_valid(ivld), .in_req_addr(iaddr), .in_req_ready(irdy[g]),
            .out_req_valid(ovld[g]), .out_req_ready(ordy),
            .out_next_card(card[g]), .out_req_addr(oaddr[g]),
            .err_backtrack(bt[g]), .err_off_mesh(om[g]),
            .err_cnt(w_cnt), .err_clr(err_clr)
        );
        for (genvar p = 0; p < NP; p++) begin : g_c
            assign cnt[g][p] = 8'(w_cnt[p]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Route at the neighbour tile, derived with plain signed integers.
    function automatic int ref_card(input int g, input logic [7:0] loc, input logic [7:0] a,
                                    output bit off);
        int nr, nc, tr, tc, rc, cc;
        nr = int'(loc[3:0]); nc = int'(loc[7:4]);
        tr = int'(a[3:0]);   tc = int'(a[7:4]);
        case (NTC[g])
            NORTH:   nr = nr - 1;
            SOUTH:   nr = nr + 1;
            EAST:    nc = nc + 1;
            WEST:    nc = nc - 1;
            default: ;
        endcase
        off = (nr < 0) || (nr > 15) || (nc < 0) || (nc > 15);
        if (off) return int'(NULL_CARDINAL);
        rc = (tr < nr) ? int'(NORTH) : (tr > nr) ? int'(SOUTH) : int'(LOCAL);
        cc = (tc < nc) ? int'(WEST)  : (tc > nc) ? int'(EAST)  : int'(LOCAL);
        if (RM[g] == ROW_FIRST) return (rc != int'(LOCAL)) ? rc : cc;
        return (cc != int'(LOCAL)) ? cc : rc;
    endfunction

    task automatic model_reset();
        for (int g = 0; g < NI; g++)
            for (int p = 0; p < NP; p++) begin
                m_vld[g][p] = 0; m_card[g][p] = int'(NULL_CARDINAL); m_addr[g][p] = 0;
                m_bt[g][p] = 0;  m_om[g][p] = 0; m_cnt[g][p] = 0;
            end
    endtask

    task automatic model_update();
        for (int g = 0; g < NI; g++)
            for (int p = 0; p < NP; p++) begin
                bit rdy, xfer, off, bte;
                int c, n;
                off = 0; bte = 0; c = 0;
                rdy  = !m_vld[g][p] || ordy[p];
                xfer = ivld[p] && rdy;
                if (xfer) begin
                    c = ref_card(g, local_id, iaddr[p], off);
                    n = int'(NTC[g]);
                    bte = (n < 4) && (c == (n + 2) % 4);
                end
                if (err_clr) begin
                    m_bt[g][p] = 0; m_om[g][p] = 0; m_cnt[g][p] = 0;
                end else if (xfer && (bte || off)) begin
                    if (bte) m_bt[g][p] = 1;
                    if (off) m_om[g][p] = 1;
                    if (m_cnt[g][p] < (1 << EW[g]) - 1) m_cnt[g][p]++;
                end
                if (xfer) begin
                    m_vld[g][p] = 1; m_card[g][p] = c; m_addr[g][p] = int'(iaddr[p]);
                end else if (ordy[p]) begin
                    m_vld[g][p] = 0;
                end
            end
    endtask

    task automatic check_all(input string ph);
        for (int g = 0; g < NI; g++)
            for (int p = 0; p < NP; p++) begin
                chk($sformatf("%s.u%0d.p%0d.vld", ph, g, p), 32'(ovld[g][p]), 32'(m_vld[g][p]));
                chk($sformatf("%s.u%0d.p%0d.rdy", ph, g, p), 32'(irdy[g][p]),
                    32'(!m_vld[g][p] || ordy[p]));
                chk($sformatf("%s.u%0d.p%0d.card", ph, g, p), 32'(card[g][p]), m_card[g][p]);
                chk($sformatf("%s.u%0d.p%0d.addr", ph, g, p), 32'(oaddr[g][p]), m_addr[g][p]);
                chk($sformatf("%s.u%0d.p%0d.bt", ph, g, p), 32'(bt[g][p]), 32'(m_bt[g][p]));
                chk($sformatf("%s.u%0d.p%0d.om", ph, g, p), 32'(om[g][p]), 32'(m_om[g][p]));
                chk($sformatf("%s.u%0d.p%0d.cnt", ph, g, p), 32'(cnt[g][p]), m_cnt[g][p]);
            end
    endtask

    task automatic step(input string ph);
        model_update();
        @(posedge clk);
        @(negedge clk);
        check_all(ph);
    endtask

    initial begin
        rst = 1'b1; err_clr = 1'b0; ivld = '0; ordy = '1; iaddr = '0; local_id = 8'h22;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Basic EAST lookahead: target row below next tile -> SOUTH.
        ivld = 5'b00001; iaddr[0] = 8'h34;
        step("t1");
        chk("t1.card", 32'(card[0][0]), 32'(SOUTH));
        chk("t1.vld", 32'(ovld[0][0]), 1);
        chk("t1.addr", 32'(oaddr[0][0]), 32'h34);
        chk("t1.noerr", 32'(cnt[0][0]), 0);

        // Column-first picks WEST (a U-turn), row-first still goes SOUTH.
        iaddr[0] = 8'h14;
        step("t2");
        chk("t2.cf.card", 32'(card[1][0]), 32'(WEST));
        chk("t2.cf.bt", 32'(bt[1][0]), 1);
        chk("t2.cf.cnt", 32'(cnt[1][0]), 1);
        chk("t2.rf.card", 32'(card[0][0]), 32'(SOUTH));
        chk("t2.rf.bt", 32'(bt[0][0]), 0);

        // WEST from column 0 leaves the mesh.
        ivld = '0; err_clr = 1'b1; local_id = 8'h01;
        step("t3clr");
        err_clr = 1'b0; ivld = 5'b00001;
        for (int i = 0; i < 3; i++) begin
            iaddr[0] = 8'($urandom);
            step("t3");
        end
        chk("t3.card", 32'(card[2][0]), 32'(NULL_CARDINAL));
        chk("t3.om", 32'(om[2][0]), 1);
        chk("t3.cnt", 32'(cnt[2][0]), 3);

        // Port 2 stalled for 5 cycles with a second request waiting.
        local_id = 8'h22; ivld = 5'b00100; iaddr[2] = 8'h57; ordy = 5'b11011;
        step("t4a");
        iaddr[2] = 8'h3c;
        for (int i = 0; i < 5; i++) begin
            step("t4s");
            chk("t4.hold", 32'(oaddr[0][2]), 32'h57);
            chk("t4.rdy", 32'(irdy[0][2]), 0);
        end
        ordy = '1;
        step("t4r");
        chk("t4.second", 32'(oaddr[0][2]), 32'h3c);
        ivld = '0;
        step("t4d");
        chk("t4.drain", 32'(ovld[0][2]), 0);

        // Two-bit counter saturates; clear beats a simultaneous error.
        err_clr = 1'b1;
        step("t5clr");
        err_clr = 1'b0; ivld = 5'b00001; iaddr[0] = 8'h12;
        for (int i = 0; i < 5; i++) step("t5");
        chk("t5.card", 32'(card[0][0]), 32'(WEST));
        chk("t5.sat", 32'(cnt[0][0]), 3);
        err_clr = 1'b1;
        step("t5x");
        chk("t5.clr.cnt", 32'(cnt[0][0]), 0);
        chk("t5.clr.bt", 32'(bt[0][0]), 0);
        err_clr = 1'b0;

        // Asynchronous reset in mid-cycle, then 1-cycle latency afterwards.
        ivld = '1;
        for (int p = 0; p < NP; p++) iaddr[p] = 8'($urandom);
        model_update();
        @(posedge clk);
        #2 rst = 1'b1;
        #1 model_reset();
        check_all("arst");
        @(negedge clk);
        #1 rst = 1'b0;
        ivld = 5'b00001; iaddr[0] = 8'h34;
        step("t6");
        chk("t6.vld", 32'(ovld[0][0]), 1);
        chk("t6.card", 32'(card[0][0]), 32'(SOUTH));

        // Randomised traffic with edge-biased tile ids.
        for (int cyc = 0; cyc < 400; cyc++) begin
            if ($urandom_range(0, 15) == 0) begin
                logic [3:0] c, r;
                c = ($urandom_range(0, 2) == 0) ? 4'd0 : ($urandom_range(0, 1) == 0) ? 4'd15 : 4'($urandom);
                r = ($urandom_range(0, 2) == 0) ? 4'd0 : ($urandom_range(0, 1) == 0) ? 4'd15 : 4'($urandom);
                local_id = {c, r};
            end
            for (int p = 0; p < NP; p++) begin
                ivld[p]  = ($urandom_range(0, 3) != 0);
                ordy[p]  = ($urandom_range(0, 9) < 7);
                iaddr[p] = 8'($urandom);
            end
            err_clr = ($urandom_range(0, 31) == 0);
            step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
